mem_arbiter: RTL and testbench

Single-port memory arbiter between the CPU core and the shared instruction/data RAM. It accepts an instruction-fetch request and a data load/store request and serialises them onto one synchronous memory port with configurable read latency. It returns fetched words, load data and completion pulses, and raises a stall request while either client is waiting.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the core-side fetch/data ports and the single memory port of mem_arbiter.
// The arbiter uses the master view; the core and the RAM model use the slave view.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_inst;
   logic        if_done;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_sel;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_done;
   logic        mem_ce;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_sel;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_req;

   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_sel, dm_wdata, mem_rdata,
      output if_inst, if_done, dm_rdata, dm_done,
      output mem_ce, mem_we, mem_addr, mem_sel, mem_wdata, stall_req
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_sel, dm_wdata, mem_rdata,
      input  if_inst, if_done, dm_rdata, dm_done,
      input  mem_ce, mem_we, mem_addr, mem_sel, mem_wdata, stall_req
   );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one synchronous RAM port
// with MEM_LAT cycles of read latency; data requests win over fetches.
module mem_arbiter #(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

   state_t      state_q,     state_d;
   logic [2:0]  cnt_q,       cnt_d;
   logic        gnt_fetch_q, gnt_fetch_d;
   logic        mem_ce_q,    mem_ce_d;
   logic        mem_we_q,    mem_we_d;
   logic [31:0] mem_addr_q,  mem_addr_d;
   logic [3:0]  mem_sel_q,   mem_sel_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] if_inst_q,   if_inst_d;
   logic        if_done_q,   if_done_d;
   logic [31:0] dm_rdata_q,  dm_rdata_d;
   logic        dm_done_q,   dm_done_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_fetch_d = gnt_fetch_q;
      mem_ce_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_sel_d   = mem_sel_q;
      mem_wdata_d = mem_wdata_q;
      if_inst_d   = if_inst_q;
      if_done_d   = 1'b0;
      dm_rdata_d  = dm_rdata_q;
      dm_done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.dm_req) begin
               state_d     = ISSUE;
               gnt_fetch_d = 1'b0;
               mem_ce_d    = 1'b1;
               mem_we_d    = bus.dm_we;
               mem_addr_d  = bus.dm_addr;
               mem_sel_d   = bus.dm_sel;
               mem_wdata_d = bus.dm_wdata;
            end else if (bus.if_req) begin
               state_d     = ISSUE;
               gnt_fetch_d = 1'b1;
               mem_ce_d    = 1'b1;
               mem_addr_d  = bus.if_addr;
               mem_sel_d   = 4'b1111;
            end
         end
         ISSUE: begin
            // Only the data port can write, so a store always completes on dm_done.
            if (mem_we_q) begin
               state_d   = DONE;
               dm_done_d = 1'b1;
            end else begin
               state_d = WAIT;
               cnt_d   = LAT_INIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = DONE;
               if (gnt_fetch_q) begin
                  if_inst_d = bus.mem_rdata;
                  if_done_d = 1'b1;
               end else begin
                  dm_rdata_d = bus.mem_rdata;
                  dm_done_d  = 1'b1;
               end
            end
         end
         DONE: begin
            // The finished requester still shows its old request here, so never grant.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         gnt_fetch_q <= 1'b0;
         mem_ce_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_sel_q   <= 4'd0;
         mem_wdata_q <= 32'd0;
         if_inst_q   <= 32'd0;
         if_done_q   <= 1'b0;
         dm_rdata_q  <= 32'd0;
         dm_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_fetch_q <= gnt_fetch_d;
         mem_ce_q    <= mem_ce_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_sel_q   <= mem_sel_d;
         mem_wdata_q <= mem_wdata_d;
         if_inst_q   <= if_inst_d;
         if_done_q   <= if_done_d;
         dm_rdata_q  <= dm_rdata_d;
         dm_done_q   <= dm_done_d;
      end
   end

   assign bus.mem_ce    = mem_ce_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_sel   = mem_sel_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_inst   = if_inst_q;
   assign bus.if_done   = if_done_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.dm_done   = dm_done_q;
   assign bus.stall_req = (bus.if_req & ~if_done_q) | (bus.dm_req & ~dm_done_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (MEM_LAT 1, 2, 4), each with a
// latency-accurate RAM model; a negedge monitor checks every issue and completion.
module tb_mem_arbiter;
   logic clk;
   logic rst;
   int   cyc;

   logic [2:0]  if_req, dm_req, dm_we;
   logic [31:0] if_addr [3];
   logic [31:0] dm_addr [3];
   logic [3:0]  dm_sel  [3];
   logic [31:0] dm_wdata[3];

   logic [2:0]  if_done_w, dm_done_w, mem_ce_w, mem_we_w, stall_w;
   logic [31:0] if_inst_w  [3];
   logic [31:0] dm_rdata_w [3];
   logic [31:0] mem_addr_w [3];
   logic [31:0] mem_wdata_w[3];
   logic [3:0]  mem_sel_w  [3];

   int          rcnt [3];
   logic [31:0] raddr[3];

   typedef struct {
      int          inst;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      int          c;
   } iss_t;

   typedef struct {
      int          inst;
      logic [1:0]  port;   // {if_done, dm_done}
      logic [31:0] data;
      int          c;
   } done_t;

   iss_t  iss_q[$];
   done_t done_q[$];

   int checks   = 0;
   int failures = 0;
   int ce_cnt[3];
   int if_done_cnt[3];
   int dm_done_cnt[3];
   int snap_if[3];
   int snap_dm[3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rd_model(logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h0000_0013;
      return {a[15:0], ~a[15:0]};
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int unsigned LAT = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
      mem_arbiter_if bus ();

      mem_arbiter #(.MEM_LAT(LAT)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus.master)
      );

      assign bus.if_req   = if_req[gi];
      assign bus.if_addr  = if_addr[gi];
      assign bus.dm_req   = dm_req[gi];
      assign bus.dm_we    = dm_we[gi];
      assign bus.dm_addr  = dm_addr[gi];
      assign bus.dm_sel   = dm_sel[gi];
      assign bus.dm_wdata = dm_wdata[gi];
      // Read data is only meaningful in cycle issue+LAT; a poison word elsewhere.
      assign bus.mem_rdata = (rcnt[gi] == 1) ? rd_model(raddr[gi]) : 32'hBADC_0FFE;

      assign if_done_w[gi]   = bus.if_done;
      assign dm_done_w[gi]   = bus.dm_done;
      assign mem_ce_w[gi]    = bus.mem_ce;
      assign mem_we_w[gi]    = bus.mem_we;
      assign stall_w[gi]     = bus.stall_req;
      assign if_inst_w[gi]   = bus.if_inst;
      assign dm_rdata_w[gi]  = bus.dm_rdata;
      assign mem_addr_w[gi]  = bus.mem_addr;
      assign mem_wdata_w[gi] = bus.mem_wdata;
      assign mem_sel_w[gi]   = bus.mem_sel;

      always @(posedge clk or posedge rst) begin
         if (rst) begin
            rcnt[gi]  <= 0;
            raddr[gi] <= 32'd0;
         end else if (bus.mem_ce && !bus.mem_we) begin
            rcnt[gi]  <= int'(LAT);
            raddr[gi] <= bus.mem_addr;
         end else if (rcnt[gi] != 0) begin
            rcnt[gi] <= rcnt[gi] - 1;
         end
      end
   end

   function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (cyc %0d)", nm, got, exp, cyc);
      end
   endfunction

   function automatic void push_iss(int inst, logic we, logic [31:0] addr, logic [3:0] sel,
                                    logic [31:0] wdata, int c);
      iss_t e;
      e.inst = inst; e.we = we; e.addr = addr; e.sel = sel; e.wdata = wdata; e.c = c;
      iss_q.push_back(e);
   endfunction

   function automatic void push_done(int inst, logic [1:0] port, logic [31:0] data, int c);
      done_t e;
      e.inst = inst; e.port = port; e.data = data; e.c = c;
      done_q.push_back(e);
   endfunction

   function automatic logic [39:0] out_or(int i);
      return {if_inst_w[i] | dm_rdata_w[i] | mem_addr_w[i] | mem_wdata_w[i], mem_sel_w[i],
              if_done_w[i], dm_done_w[i], mem_ce_w[i], mem_we_w[i]};
   endfunction

   // Monitor: compares every memory issue and every completion against the scoreboard.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk("we_outside_issue", 64'(mem_we_w[i] & ~mem_ce_w[i]), 64'd0);
         if (mem_ce_w[i]) begin
            ce_cnt[i]++;
            chk("issue_expected", 64'(iss_q.size() != 0), 64'd1);
            if (iss_q.size() != 0) begin
               iss_t e;
               e = iss_q.pop_front();
               chk("issue_inst", 64'(i), 64'(e.inst));
               chk("issue_fields", {27'd0, mem_we_w[i], mem_addr_w[i], mem_sel_w[i]},
                   {27'd0, e.we, e.addr, e.sel});
               chk("issue_wdata", 64'(e.we ? mem_wdata_w[i] : 32'd0),
                   64'(e.we ? e.wdata : 32'd0));
               chk("issue_cycle", 64'(cyc), 64'(e.c));
            end
         end
         if (if_done_w[i] || dm_done_w[i]) begin
            logic [31:0] d;
            if (if_done_w[i]) if_done_cnt[i]++;
            if (dm_done_w[i]) dm_done_cnt[i]++;
            d = if_done_w[i] ? if_inst_w[i] : dm_rdata_w[i];
            $display("txn inst=%0d done=%b data=%h cyc=%0d", i, {if_done_w[i], dm_done_w[i]},
                     d, cyc);
            chk("done_expected", 64'(done_q.size() != 0), 64'd1);
            if (done_q.size() != 0) begin
               done_t e;
               e = done_q.pop_front();
               chk("done_inst", 64'(i), 64'(e.inst));
               chk("done_port", 64'({if_done_w[i], dm_done_w[i]}), 64'(e.port));
               chk("done_data", 64'(d), 64'(e.data));
               chk("done_cycle", 64'(cyc), 64'(e.c));
            end
         end
      end
   end

   task automatic start_fetch(int i, logic [31:0] a);
      snap_if[i] = if_done_cnt[i];
      if_addr[i] = a;
      if_req[i]  = 1'b1;
   endtask

   task automatic start_data(int i, logic we, logic [31:0] a, logic [3:0] sel, logic [31:0] wd);
      snap_dm[i]  = dm_done_cnt[i];
      dm_we[i]    = we;
      dm_addr[i]  = a;
      dm_sel[i]   = sel;
      dm_wdata[i] = wd;
      dm_req[i]   = 1'b1;
   endtask

   // Drops each request after its done pulse and waits for the scoreboard to drain.
   task automatic run(int i, int max_cyc);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < max_cyc && !ok; k++) begin
         @(posedge clk); #1;
         if (if_done_cnt[i] != snap_if[i]) if_req[i] = 1'b0;
         if (dm_done_cnt[i] != snap_dm[i]) dm_req[i] = 1'b0;
         if (iss_q.size() == 0 && done_q.size() == 0 && !if_req[i] && !dm_req[i]) ok = 1'b1;
      end
      chk("run_complete", 64'(ok), 64'd1);
      if (!ok) begin
         iss_q.delete();
         done_q.delete();
         if_req[i] = 1'b0;
         dm_req[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int ce0;
      int d0;
      cyc    = 0;
      if_req = 3'b000;
      dm_req = 3'b000;
      dm_we  = 3'b000;
      for (int i = 0; i < 3; i++) begin
         if_addr[i] = 32'd0; dm_addr[i] = 32'd0; dm_sel[i] = 4'd0; dm_wdata[i] = 32'd0;
         ce_cnt[i] = 0; if_done_cnt[i] = 0; dm_done_cnt[i] = 0; snap_if[i] = 0; snap_dm[i] = 0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("reset_outputs", 64'(out_or(i)), 64'd0);
         chk("reset_stall", 64'(stall_w[i]), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Single fetch, MEM_LAT=1.
      @(posedge clk); #1;
      t0 = cyc;
      start_fetch(0, 32'h0000_0010);
      push_iss(0, 1'b0, 32'h0000_0010, 4'hF, 32'd0, t0 + 1);
      push_done(0, 2'b10, 32'h0000_0013, t0 + 3);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("fetch_stall", 64'(stall_w[0]), 64'(c < 3));
      end
      run(0, 20);

      // Store, MEM_LAT=1; dm_rdata keeps its (reset) value.
      @(posedge clk); #1;
      t0 = cyc;
      start_data(0, 1'b1, 32'h0000_0100, 4'b0011, 32'hDEAD_BEEF);
      push_iss(0, 1'b1, 32'h0000_0100, 4'b0011, 32'hDEAD_BEEF, t0 + 1);
      push_done(0, 2'b01, 32'h0000_0000, t0 + 2);
      run(0, 20);
      chk("store_if_inst_held", 64'(if_inst_w[0]), 64'h0000_0013);

      // Simultaneous load and fetch, MEM_LAT=2: load first, then the fetch.
      @(posedge clk); #1;
      t0  = cyc;
      ce0 = ce_cnt[1];
      start_data(1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);
      start_fetch(1, 32'h0000_0040);
      push_iss(1, 1'b0, 32'h0000_0200, 4'hF, 32'd0, t0 + 1);
      push_done(1, 2'b01, 32'h0200_FDFF, t0 + 4);
      push_iss(1, 1'b0, 32'h0000_0040, 4'hF, 32'd0, t0 + 6);
      push_done(1, 2'b10, 32'h0040_FFBF, t0 + 9);
      run(1, 40);
      chk("both_ce_count", 64'(ce_cnt[1] - ce0), 64'd2);

      // MEM_LAT=4 load: data valid only in cycle 5, held after dm_done.
      @(posedge clk); #1;
      t0 = cyc;
      start_data(2, 1'b0, 32'h0000_0300, 4'b1100, 32'h0);
      push_iss(2, 1'b0, 32'h0000_0300, 4'b1100, 32'd0, t0 + 1);
      push_done(2, 2'b01, 32'h0300_FCFF, t0 + 6);
      run(2, 40);
      chk("lat4_dm_rdata_held", 64'(dm_rdata_w[2]), 64'h0300_FCFF);

      // Fetch whose request drops in cycle 2 still completes, with one issue only.
      @(posedge clk); #1;
      t0  = cyc;
      ce0 = ce_cnt[0];
      start_fetch(0, 32'h0000_0020);
      push_iss(0, 1'b0, 32'h0000_0020, 4'hF, 32'd0, t0 + 1);
      push_done(0, 2'b10, 32'h0020_FFDF, t0 + 3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      if_req[0] = 1'b0;
      run(0, 20);
      chk("drop_ce_count", 64'(ce_cnt[0] - ce0), 64'd1);

      // Reset during WAIT of a MEM_LAT=2 fetch: no done, outputs cleared, then a clean fetch.
      @(posedge clk); #1;
      t0 = cyc;
      d0 = if_done_cnt[1];
      start_fetch(1, 32'h0000_0040);
      push_iss(1, 1'b0, 32'h0000_0040, 4'hF, 32'd0, t0 + 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_wait_outputs", 64'(out_or(1)), 64'd0);
      if_req[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_wait_no_done", 64'(if_done_cnt[1] - d0), 64'd0);
      @(posedge clk); #1;
      t0 = cyc;
      start_fetch(1, 32'h0000_0040);
      push_iss(1, 1'b0, 32'h0000_0040, 4'hF, 32'd0, t0 + 1);
      push_done(1, 2'b10, 32'h0040_FFBF, t0 + 4);
      run(1, 20);

      // Reset in the ISSUE cycle drops mem_ce without a clock edge.
      @(posedge clk); #1;
      t0 = cyc;
      start_fetch(0, 32'h0000_0010);
      push_iss(0, 1'b0, 32'h0000_0010, 4'hF, 32'd0, t0 + 1);
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("issue_ce_high", 64'(mem_ce_w[0]), 64'd1);
      rst = 1'b1;
      #1;
      chk("async_ce_drop", 64'(mem_ce_w[0]), 64'd0);
      if_req[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      chk("sb_issue_drained", 64'(iss_q.size()), 64'd0);
      chk("sb_done_drained", 64'(done_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
